// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared definitions for the 4x4 keypad scanner and the
//               downstream code-entry decoder: matrix geometry, scan-state
//               encoding, onehot key constants and a multi-key helper.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int KEY_BITS = KEY_ROWS * KEY_COLS;

    // One state per driven column.
    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } scan_state_e;

    // Onehot key codes, bit index = row*4 + col.
    // Physical layout:  row0: 1 2 3 SET
    //                   row1: 4 5 6 RESET
    //                   row2: 7 8 9 LOCK
    //                   row3: CLEAR 0 ENTER (spare)
    localparam logic [15:0] KEY_1     = 16'h0001;
    localparam logic [15:0] KEY_2     = 16'h0002;
    localparam logic [15:0] KEY_3     = 16'h0004;
    localparam logic [15:0] KEY_SET   = 16'h0008;
    localparam logic [15:0] KEY_4     = 16'h0010;
    localparam logic [15:0] KEY_5     = 16'h0020;
    localparam logic [15:0] KEY_6     = 16'h0040;
    localparam logic [15:0] KEY_RESET = 16'h0080;
    localparam logic [15:0] KEY_7     = 16'h0100;
    localparam logic [15:0] KEY_8     = 16'h0200;
    localparam logic [15:0] KEY_9     = 16'h0400;
    localparam logic [15:0] KEY_LOCK  = 16'h0800;
    localparam logic [15:0] KEY_CLEAR = 16'h1000;
    localparam logic [15:0] KEY_0     = 16'h2000;
    localparam logic [15:0] KEY_ENTER = 16'h4000;

    // True when two or more bits are set (clearing the lowest set bit
    // leaves something behind).
    function automatic logic multi_key(input logic [KEY_BITS-1:0] v);
        return (v & (v - KEY_BITS'(1))) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_if
// Description : Keypad matrix pins plus the debounced key outputs.
//   row_in    : keypad rows, active low (driven by the keypad side)
//   col_out   : column drive, active low, one bit low at a time
//   onehot    : debounced key vector, bit = row*4 + col, 0 = no key
//   key_valid : |onehot
//   key_press : one-cycle pulse on a new nonzero commit
//   master = scanner, slave = keypad / downstream consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KEY_ROWS-1:0] row_in;
    logic [KEY_COLS-1:0] col_out;
    logic [KEY_BITS-1:0] onehot;
    logic                key_valid;
    logic                key_press;

    modport master (
        input  row_in,
        output col_out,
        output onehot,
        output key_valid,
        output key_press
    );

    modport slave (
        output row_in,
        input  col_out,
        input  onehot,
        input  key_valid,
        input  key_press
    );

endinterface
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keypad_debounce
// Description : Whole-frame debouncer. Counts consecutive identical frames
//               and commits a frame to onehot once it has been seen
//               DEBOUNCE_SCANS times in a row, rejecting multi-key frames.
//   clk, rst_n : clock, asynchronous active-low reset
//   frame_end  : one-cycle strobe, frame is complete this cycle
//   frame      : full 16-bit pressed snapshot
//   onehot     : committed key vector
//   key_valid  : |onehot
//   key_press  : one-cycle pulse when onehot takes a new nonzero value
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_end,
    input  logic [KEY_BITS-1:0] frame,
    output logic [KEY_BITS-1:0] onehot,
    output logic                key_valid,
    output logic                key_press
);

    localparam int              CNT_W        = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] c_CNT_COMMIT = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [KEY_BITS-1:0] r_prev;
    logic [CNT_W-1:0]    r_cnt;
    logic [KEY_BITS-1:0] r_onehot;
    logic                r_valid;
    logic                r_press;

    logic w_match;
    logic w_commit;
    logic w_accept;

    assign w_match  = (frame == r_prev);
    // Commit fires only on the step into saturation, so a held key
    // commits exactly once.
    assign w_commit = frame_end && w_match && (r_cnt == c_CNT_COMMIT);
    // Multi-key (ghost) frames consume the commit but leave onehot alone.
    assign w_accept = w_commit && !multi_key(frame);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= '0;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (frame_end) begin
                r_prev <= frame;
                if (w_match) begin
                    r_cnt <= (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + CNT_W'(1);
                end else begin
                    r_cnt <= CNT_W'(1);
                end
            end
            if (w_accept) begin
                r_onehot <= frame;
                r_valid  <= |frame;
                r_press  <= (frame != '0) && (frame != r_onehot);
            end
        end
    end

    assign onehot    = r_onehot;
    assign key_valid = r_valid;
    assign key_press = r_press;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 passive matrix keypad scanner. Drives one column low at
//               a time for SCAN_DIV cycles, samples the synchronized rows at
//               the last cycle of each column, assembles a 16-bit frame and
//               hands it to the debouncer at the end of COL3.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kp    : keypad_scanner_if.master (row_in, col_out, onehot, key_valid,
//           key_press)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);

    localparam int               DIV_W      = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [1:0] c_ST_COL0 = COL0;
    localparam logic [1:0] c_ST_COL1 = COL1;
    localparam logic [1:0] c_ST_COL2 = COL2;
    localparam logic [1:0] c_ST_COL3 = COL3;

    logic [KEY_ROWS-1:0] r_row_meta;
    logic [KEY_ROWS-1:0] r_row_s;
    logic [DIV_W-1:0]    r_div;
    logic [1:0]          r_state;
    logic [KEY_COLS-1:0] r_col;
    logic [KEY_BITS-1:0] r_acc;

    logic [KEY_ROWS-1:0] w_pressed;
    logic                w_sample;
    logic                w_frame_end;
    logic [1:0]          w_state_next;
    logic [KEY_BITS-1:0] w_acc_next;

    // Two-flop synchronizer; rows idle high, so reset to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= '1;
            r_row_s    <= '1;
        end else begin
            r_row_meta <= kp.row_in;
            r_row_s    <= r_row_meta;
        end
    end

    assign w_pressed   = ~r_row_s;
    // Sampling on the last divider cycle leaves the column settle time plus
    // the synchronizer latency behind us.
    assign w_sample    = (r_div == c_DIV_LAST);
    assign w_frame_end = w_sample && (r_state == c_ST_COL3);

    always_comb begin
        w_state_next = c_ST_COL0;
        case (r_state)
            c_ST_COL0: w_state_next = c_ST_COL1;
            c_ST_COL1: w_state_next = c_ST_COL2;
            c_ST_COL2: w_state_next = c_ST_COL3;
            c_ST_COL3: w_state_next = c_ST_COL0;
            default:   w_state_next = c_ST_COL0;
        endcase
    end

    // Accumulator with the current column's rows merged in. At frame end
    // this is the complete frame including the COL3 bits of this cycle.
    always_comb begin
        w_acc_next = r_acc;
        for (int r = 0; r < KEY_ROWS; r++) begin
            for (int c = 0; c < KEY_COLS; c++) begin
                if (r_state == 2'(c)) begin
                    w_acc_next[r*KEY_COLS + c] = w_pressed[r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_state <= c_ST_COL0;
            r_col   <= 4'b1110;
            r_acc   <= '0;
        end else if (w_sample) begin
            r_div   <= '0;
            r_state <= w_state_next;
            // Column drive is registered so it never glitches between states.
            r_col   <= ~(4'b0001 << w_state_next);
            r_acc   <= w_acc_next;
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_end (w_frame_end),
        .frame     (w_acc_next),
        .onehot    (kp.onehot),
        .key_valid (kp.key_valid),
        .key_press (kp.key_press)
    );

    assign kp.col_out = r_col;

endmodule
`default_nettype wire
